// File: rtl/freq_tick_gen_pkg.sv
// Shared constants for the tick generator: counter width, reset divisor and
// divisors for the standard board rates derived from the 50 MHz clock.
package freq_tick_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int CNT_W_DEFAULT     = 28;
  localparam int DEFAULT_DIV_VALUE = 25_000_000;

  // Divisor giving one tick per period of the requested tick rate.
  function automatic int hz_to_div(input int tick_hz);
    return CLK_HZ / tick_hz;
  endfunction

  localparam int DIV_MUX_95HZ  = hz_to_div(95);
  localparam int DIV_BLINK_2HZ = hz_to_div(2);
  localparam int DIV_TIMER_1HZ = hz_to_div(1);

endpackage

// File: rtl/freq_tick_gen_tick_channel.sv
// One divider channel: up-counter, active and pending divisor, registered
// one-cycle tick and a square output that toggles on every tick.
module tick_channel
  import freq_tick_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_value,
  output logic             tick,
  output logic             square,
  output logic             pending
);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             pending_reg, pending_next;
  logic             tick_reg, tick_next;
  logic             square_reg, square_next;
  logic             halted;
  logic             terminal;

  assign halted   = (div_reg == '0);
  assign terminal = (count_reg == div_reg - CNT_W'(1));

  always_comb begin
    count_next    = count_reg;
    div_next      = div_reg;
    pend_div_next = pend_div_reg;
    pending_next  = pending_reg;
    tick_next     = 1'b0;
    square_next   = square_reg;

    if (sync_clear) begin
      count_next  = '0;
      square_next = 1'b0;
      if (load_en) begin
        div_next     = load_value;
        pending_next = 1'b0;
      end else if (pending_reg) begin
        div_next     = pend_div_reg;
        pending_next = 1'b0;
      end
    end else if (!enable || halted) begin
      // An idle channel has no period in flight, so a new divisor can land now.
      if (load_en) begin
        div_next     = load_value;
        count_next   = '0;
        pending_next = 1'b0;
      end else if (halted) begin
        count_next = '0;
      end
    end else if (terminal) begin
      count_next  = '0;
      tick_next   = 1'b1;
      square_next = ~square_reg;
      if (load_en) begin
        div_next     = load_value;
        pending_next = 1'b0;
      end else if (pending_reg) begin
        div_next     = pend_div_reg;
        pending_next = 1'b0;
      end
    end else begin
      count_next = count_reg + CNT_W'(1);
      if (load_en) begin
        pend_div_next = load_value;
        pending_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      count_reg    <= '0;
      div_reg      <= CNT_W'(DEFAULT_DIV);
      pend_div_reg <= '0;
      pending_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      square_reg   <= 1'b0;
    end else begin
      count_reg    <= count_next;
      div_reg      <= div_next;
      pend_div_reg <= pend_div_next;
      pending_reg  <= pending_next;
      tick_reg     <= tick_next;
      square_reg   <= square_next;
    end
  end

  assign tick    = tick_reg;
  assign square  = square_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/freq_tick_gen.sv
// Multi-channel programmable tick generator; ticks are clock enables for
// downstream timers, never clocks.
module freq_tick_gen
  import freq_tick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync_clear,
  input  logic              div_load,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square,
  output logic [NUM_CH-1:0] div_pending
);

  logic [NUM_CH-1:0] load_en;

  // Selects beyond NUM_CH match no channel, so such loads are dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign load_en[gi] = div_load && (int'(div_sel) == gi);

    tick_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_channel (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (ch_enable[gi]),
      .sync_clear(sync_clear),
      .load_en   (load_en[gi]),
      .load_value(div_value),
      .tick      (tick[gi]),
      .square    (square[gi]),
      .pending   (div_pending[gi])
    );
  end

endmodule

// File: doc/freq_tick_gen.md
Name: freq_tick_gen

Overview:
- Parametrised successor to the free-running clock divider.
- Provides NUM_CH independent channels. Each channel has a runtime-programmable divisor and emits a one-cycle enable pulse (tick) plus a 50 % duty square output.
- Divisor changes are glitch-free: they are deferred to the channel's terminal count.
- Sits between the 50 MHz board clock and the scoreboard timers and display multiplexers. Consumers use tick as a clock enable and never as a derived clock.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 28, counter and divisor width in bits.
- DEFAULT_DIV, 25000000, divisor loaded into every channel at reset (0.5 s tick, 1 Hz square at 50 MHz).
- SEL_W, $clog2(NUM_CH) (minimum 1), width of div_sel.

Ports:
- clock_in  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ch_enable  in  NUM_CH  per-channel run enable.
- sync_clear  in  1  phase-align strobe; clears all channels at once.
- div_load  in  1  single-cycle divisor write strobe.
- div_sel  in  SEL_W  target channel of div_load.
- div_value  in  CNT_W  new divisor.
- tick  out  NUM_CH  one-cycle pulse per divisor period, registered.
- square  out  NUM_CH  toggles on every tick; period 2*D, registered.
- div_pending  out  NUM_CH  high while a loaded divisor waits for terminal count.

Behaviour:
- Clock and reset: one clock (clock_in); reset is synchronous and active-high. All state updates on the rising edge of clock_in.
- Reset, highest priority: per channel count=0, div=DEFAULT_DIV, pend_div=0, div_pending=0, tick=0, square=0.
- Per-channel state: count[CNT_W], div[CNT_W], pend_div[CNT_W], pending flag.
- Enabled, D=div>=1, count!=D-1: count<=count+1, tick<=0.
- Enabled, count==D-1 (terminal):
  - count<=0, tick<=1, square<=~square.
  - If pending: div<=pend_div, pending<=0.
- Tick timing: first tick is high in the cycle after the D-th enabled edge counted from count=0. Tick period is exactly D cycles. D=1 gives tick high continuously and square toggling every cycle.
- D=0: channel halted. count held at 0, tick=0, square held. A later load is applied immediately, because the channel counts as idle.
- Disabled (ch_enable=0): count and square hold, tick<=0. A load to a disabled channel is applied on the next edge: div<=div_value, count<=0, pending stays 0.
- Load to an enabled channel: pend_div<=div_value, pending<=1. A second load before terminal count overwrites pend_div, and only the last value is applied.
- Load in the same cycle as terminal count: div_value becomes div directly for the next period, and pending stays 0.
- div_sel>=NUM_CH: load ignored, no state change.
- sync_clear (below reset, above everything else):
  - All channels: count<=0, tick<=0, square<=0.
  - Pending divisors are applied (div<=pend_div, pending<=0).
  - A load in the same cycle is applied directly.
- No wrap-around: count never exceeds D-1. The maximum divisor is 2^CNT_W-1.
- Channels are fully independent apart from reset and sync_clear.

Decomposition:
- Shared package freq_tick_pkg holds:
  - CNT_W default.
  - DEFAULT_DIV.
  - Helper constant for the 50 MHz input frequency.
  - Divisor constants for 95 Hz multiplex, 2 Hz blink and 1 Hz timer rates.
- One sub-module, tick_channel, holds counter, divisor, pending logic, tick and square for one channel. It takes per-channel load_en and sync_clear.
- The top level decodes div_sel into load_en and instantiates NUM_CH copies with a generate loop.

Test Plan:
- Reset, then DEFAULT_DIV overridden to 4, ch_enable=1 on channel 0 -> tick[0] high for 1 cycle every 4 cycles, first tick 4 cycles after enable; square[0] period 8, 50 % duty.
- Channel 1 running D=10, load 3 at count=5 -> div_pending[1]=1 until terminal count (4 more cycles). Remaining period stays 10; subsequent ticks every 3 cycles, with no short or runt pulse.
- Channel 2 disabled, load 7 -> applied next edge, count=0, div_pending stays 0. Enable -> first tick 7 cycles later.
- Load D=0 on a running channel -> after terminal count the channel halts, tick stays 0, square frozen. Load 2 -> ticks resume every 2 cycles.
- Channels 0–3 at D=3,5,7,9 run freely, then assert sync_clear -> all squares 0 and counts 0; next ticks at 3,5,7,9 cycles after the clear. Pending loads are applied.
- Load with div_sel=NUM_CH (out of range) -> no output change. Reset asserted mid-period -> all outputs 0 on the next edge and divisors back to DEFAULT_DIV.
